// File: rtl/wb2uart_pkg.sv
// Shared types and constants for the WB2UART front-end arbiter.
// Command encodings, word layout and arbiter state encoding.
package wb2uart_pkg;

   localparam logic [1:0] CMD_READ  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_ABORT = 2'b11;
   localparam int         WORD_W    = 34;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [31:0] data;
   } wb2uart_word_t;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP} arb_state_t;

   // The encoder treats this command as a synchronous reset, so it must never be forwarded.
   function automatic logic is_abort(input wb2uart_word_t w);
      return w.cmd == CMD_ABORT;
   endfunction

endpackage

// File: rtl/wb2uart_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Reusable; ptr is expected to stay below N_REQ.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     any
);

   localparam int IDX_W = $clog2(N_REQ);

   function automatic int wrap(input int a);
      return (a >= N_REQ) ? a - N_REQ : a;
   endfunction

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!any && req[wrap(int'(ptr) + k)]) begin
            any                       = 1'b1;
            gnt[wrap(int'(ptr) + k)]  = 1'b1;
            idx                       = IDX_W'(wrap(int'(ptr) + k));
         end
      end
   end

endmodule

// File: rtl/wb2uart_arbiter.sv
// Round-robin arbiter sharing one WB2UART encoder between N_REQ requesters.
// Serialises frames, filters the abort command and times out a missing stall response.
module wb2uart_arbiter
   import wb2uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WORD_W-1:0]  req_word,
   output logic [N_REQ-1:0]         req_ready,
   output logic [WORD_W-1:0]        out_WB2UART_word,
   output logic                     out_WB2UART_cyc,
   input  logic                     in_WB2UART_stall,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     err_cmd,
   output logic                     err_timeout
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   arb_state_t                   state, state_nxt;
   logic [IDX_W-1:0]             rr_ptr, win_idx;
   logic [N_REQ-1:0]             win_gnt;
   logic                         any_req, accept, timeout_hit;
   logic [CNT_W-1:0]             cnt;
   logic [N_REQ-1:0][WORD_W-1:0] words;
   wb2uart_word_t                win_word;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (any_req)
   );

   assign words    = req_word;
   assign win_word = words[win_idx];

   // Stall gating also covers a frame left running across a reset or external encoder use.
   assign accept      = (state == IDLE) && any_req && !in_WB2UART_stall;
   assign req_ready   = accept ? win_gnt : '0;
   assign busy        = (state != IDLE);
   assign timeout_hit = (state == WAIT_START) && !in_WB2UART_stall &&
                        (cnt == CNT_W'(START_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (accept && !is_abort(win_word)) state_nxt = ISSUE;
         ISSUE:      state_nxt = WAIT_START;
         WAIT_START: if (in_WB2UART_stall) state_nxt = WAIT_DONE;
                     else if (timeout_hit)  state_nxt = GAP;
         WAIT_DONE:  if (!in_WB2UART_stall) state_nxt = GAP;
         GAP:        state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr           <= '0;
         grant_id         <= '0;
         out_WB2UART_word <= '0;
         out_WB2UART_cyc  <= 1'b0;
         err_cmd          <= 1'b0;
         err_timeout      <= 1'b0;
         cnt              <= '0;
      end else begin
         out_WB2UART_cyc <= (state_nxt == ISSUE);
         err_cmd         <= accept && is_abort(win_word);
         err_timeout     <= timeout_hit;
         if (accept) begin
            grant_id <= win_idx;
            rr_ptr   <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (!is_abort(win_word)) out_WB2UART_word <= win_word;
         end
         if (state == ISSUE)                             cnt <= '0;
         else if (state == WAIT_START && !in_WB2UART_stall) cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb2uart_arbiter.sv
// Bench for wb2uart_arbiter: directed scenarios plus a randomized phase, all checked
// every cycle against a transaction-level model built from the arbitration rules.
module tb_wb2uart_arbiter;
   import wb2uart_pkg::*;

   localparam int N  = 4;
   localparam int TO = 15;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [N-1:0]        req_valid, req_ready;
   logic [N*WORD_W-1:0] req_word;
   logic [WORD_W-1:0]   out_word;
   logic                cyc, stall, busy, err_cmd, err_timeout;
   logic [1:0]          grant_id;

   always #5 clk = ~clk;

   wb2uart_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_word         (req_word),
      .req_ready        (req_ready),
      .out_WB2UART_word (out_word),
      .out_WB2UART_cyc  (cyc),
      .in_WB2UART_stall (stall),
      .grant_id         (grant_id),
      .busy             (busy),
      .err_cmd          (err_cmd),
      .err_timeout      (err_timeout)
   );

   int n_cmp = 0, n_err = 0;
   // model: cycle index and the cycles at which events are due
   int n = 0, idle_at = 0, cyc_due = -1, errc_due = -1, errt_due = -1;
   int rise_at = -1, fall_at = -1;
   int m_ptr = 0;
   logic [1:0]        m_grant = '0;
   logic [WORD_W-1:0] m_word  = '0;
   // stimulus controls
   logic [N-1:0]      v_drv = '0;
   logic [WORD_W-1:0] w_drv [N];
   bit hold = 1'b0, ext_req = 1'b0, rnd_frame = 1'b0;
   int f_d = 1, f_len = 4;
   // observations
   int order[$];
   int last_cyc_n = 0, last_acc_n = 0, n_to = 0, to_delay = 0, rst_fall = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      @(posedge clk);
      n++;
      #1;
      stall     = (ext_req && n >= idle_at) || (n >= rise_at && n < fall_at);
      req_valid = v_drv;
      for (int k = 0; k < N; k++) req_word[k*WORD_W +: WORD_W] = w_drv[k];
   endtask

   task automatic check_cycle();
      logic [N-1:0] er;
      int w, d, len;
      @(negedge clk);
      er = '0;
      w  = -1;
      if (n >= idle_at && !stall)
         for (int k = 0; k < N; k++)
            if (w < 0 && v_drv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready",    req_ready,    er);
      chk("busy",         busy,         n < idle_at);
      chk("cyc",          cyc,          n == cyc_due);
      chk("err_cmd",      err_cmd,      n == errc_due);
      chk("err_timeout",  err_timeout,  n == errt_due);
      chk("grant_id",     grant_id,     m_grant);
      chk("out_word",     out_word,     m_word);
      chk("cyc_in_stall", cyc & stall,  1'b0);
      if (cyc) last_cyc_n = n;
      if (err_timeout) begin n_to++; to_delay = n - last_cyc_n; end
      if (|(req_ready & req_valid)) begin
         last_acc_n = n;
         for (int k = 0; k < N; k++) if (req_ready[k]) order.push_back(k);
      end
      if (w >= 0) begin
         m_grant = 2'(w);
         m_ptr   = (w + 1) % N;
         if (w_drv[w][33:32] == CMD_ABORT) errc_due = n + 1;
         else begin
            m_word  = w_drv[w];
            cyc_due = n + 1;
            d   = rnd_frame ? int'($urandom_range(0, 7))  : f_d;
            len = rnd_frame ? int'($urandom_range(1, 12)) : f_len;
            if (d == 0) begin
               rise_at  = -1;
               fall_at  = -1;
               errt_due = n + TO + 2;
               idle_at  = n + TO + 3;
            end else begin
               rise_at = n + 1 + d;
               fall_at = rise_at + len;
               idle_at = fall_at + 2;
            end
         end
         if (!hold) v_drv[w] = 1'b0;
      end
   endtask

   task automatic step();
      drive();
      check_cycle();
   endtask

   task automatic run_accepts(input int k, input int budget, input string tag);
      int c = 0;
      while (order.size() < k && c < budget) begin step(); c++; end
      chk(tag, order.size() >= k, 1'b1);
   endtask

   task automatic wait_idle();
      int c = 0;
      while (n < idle_at + 1 && c < 100) begin step(); c++; end
   endtask

   task automatic mid_reset();
      drive();
      #1 rst = 1'b0;
      #1;
      chk("rst_busy",  busy,        1'b0);
      chk("rst_cyc",   cyc,         1'b0);
      chk("rst_grant", grant_id,    2'd0);
      chk("rst_word",  out_word,    '0);
      chk("rst_errc",  err_cmd,     1'b0);
      chk("rst_errt",  err_timeout, 1'b0);
      chk("rst_ready", req_ready,   '0);
      idle_at = n; cyc_due = -1; errc_due = -1; errt_due = -1;
      m_ptr = 0; m_grant = '0; m_word = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      stall = 1'b0; req_valid = '0; req_word = '0;
      for (int k = 0; k < N; k++) w_drv[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_busy",  busy,        1'b0);
      chk("init_cyc",   cyc,         1'b0);
      chk("init_word",  out_word,    '0);
      chk("init_grant", grant_id,    2'd0);
      chk("init_err",   {err_cmd, err_timeout}, 2'b00);
      @(negedge clk);
      rst = 1'b1;

      // single request
      w_drv[0] = {CMD_WRITE, 32'hDEADBEEF};
      v_drv = 4'b0001; f_d = 1; f_len = 40;
      run_accepts(1, 20, "single_budget");
      chk("single_idx", order[0], 0);
      repeat (3) step();
      chk("single_word", out_word, 34'h1DEADBEEF);
      wait_idle();

      // round robin from ptr 0
      mid_reset();
      order.delete();
      for (int k = 0; k < N; k++) w_drv[k] = {2'($urandom_range(0, 1)), $urandom()};
      v_drv = '1; hold = 1'b1; f_d = 2; f_len = 3;
      run_accepts(5, 200, "rr_budget");
      v_drv = '0; hold = 1'b0;
      for (int i = 0; i < 5; i++) chk("rr_order", order[i], i % N);
      wait_idle();

      // abort filter
      order.delete();
      w_drv[1] = {CMD_ABORT, 32'h0};
      v_drv = 4'b0010;
      run_accepts(1, 40, "abort_budget");
      step();
      chk("abort_errcmd", err_cmd, 1'b1);
      chk("abort_idle",   busy,    1'b0);
      w_drv[0] = {CMD_READ, 32'h0000_1111};
      w_drv[2] = {CMD_WRITE, 32'h2222_0000};
      v_drv = 4'b0101;
      run_accepts(3, 60, "abort_next_budget");
      chk("abort_next", order[1], 2);
      wait_idle();

      // timeout, then the next requester is served
      order.delete(); n_to = 0;
      w_drv[3] = {CMD_READ, 32'hCAFE_F00D};
      w_drv[0] = {CMD_WRITE, 32'h0BAD_CAFE};
      v_drv = 4'b1001; f_d = 0;
      run_accepts(1, 40, "to_budget");
      f_d = 2; f_len = 5;
      run_accepts(2, 60, "to_next_budget");
      chk("to_first",  order[0], 3);
      chk("to_second", order[1], 0);
      chk("to_count",  n_to, 1);
      chk("to_delay",  to_delay, TO + 1);
      wait_idle();

      // reset during WAIT_DONE with the encoder still stalled
      order.delete();
      w_drv[0] = {CMD_WRITE, 32'h1234_5678};
      v_drv = 4'b0001; f_d = 1; f_len = 30;
      run_accepts(1, 40, "mid_budget");
      rst_fall = fall_at;
      repeat (5) step();
      v_drv = 4'b0001;
      mid_reset();
      order.delete();
      run_accepts(1, 60, "post_rst_budget");
      chk("post_rst_wait", last_acc_n == rst_fall, 1'b1);
      wait_idle();

      // encoder stalled by someone else while idle
      order.delete();
      ext_req = 1'b1; v_drv = 4'b0001;
      repeat (6) step();
      chk("ext_no_accept", order.size(), 0);
      ext_req = 1'b0;
      run_accepts(1, 5, "ext_budget");
      wait_idle();

      // randomized traffic
      rnd_frame = 1'b1;
      for (int i = 0; i < 800; i++) begin
         v_drv = 4'($urandom());
         for (int k = 0; k < N; k++) w_drv[k] = {2'($urandom_range(0, 3)), $urandom()};
         ext_req = ($urandom_range(0, 15) == 0);
         step();
      end
      v_drv = '0; ext_req = 1'b0;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
